ram_writer: RTL and testbench
=============================

Name: ram_writer

Overview:
- Accepts an AXI-Stream of data beats and writes them sequentially into RAM, starting at address 0, over an AXI4 memory-mapped write interface.
- Transfers are organised as N full blocks followed by an optional partial block.
- Write-side companion of the RAM read-back path: it fills the RAM that the reader later drains.
- Completion is reported only after every write response has been received.

Parameters:
- DW, 512, data width in bits (AXIS and AXI W/R data).
- IW, 5, AXI ID width.
- BLOCK_CYCLES, 64, data beats per full block (1..256); full-burst AWLEN = BLOCK_CYCLES-1.
- BURST_BYTES, BLOCK_CYCLES*DW/8, address increment per burst (derived, not overridden).

Ports:
- clk  in  1  clock; all logic rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- full_blocks  in  32  number of full blocks to write; sampled on start.
- partial_block_cycles  in  8  beats in the trailing partial block, 0 = none; sampled on start.
- start  in  1  single-cycle pulse that begins a transfer; honoured only when idle.
- idle  out  1  high when no transfer is in progress and start is low.
- bresp_error  out  1  sticky; set on any BRESP != 0; cleared by start or reset.
- AXIS_IN_TDATA  in  DW  input data.
- AXIS_IN_TVALID  in  1  input data valid.
- AXIS_IN_TREADY  out  1  input ready.
- M_AXI_AW*  out/in  std  AWADDR 64, AWLEN 8, AWSIZE 3, AWID IW, AWBURST 2, AWLOCK 1, AWCACHE 4, AWQOS 4, AWPROT 3, AWVALID out; AWREADY in.
- M_AXI_W*  out/in  std  WDATA DW, WSTRB DW/8, WVALID, WLAST out; WREADY in.
- M_AXI_B*  in/out  std  BRESP 2, BVALID in; BREADY out.
- M_AXI_AR*/R*  std  read channels unused: all outputs tied 0; inputs ignored.

Behaviour:
- Constants: AWSIZE=$clog2(DW/8), AWBURST=1 (INCR), AWID/LOCK/CACHE/QOS/PROT=0, WSTRB=all ones, BREADY=1.
- On start while idle: latch FB=full_blocks and PB=partial_block_cycles.
  - total_bursts = FB + (PB!=0), 33-bit.
  - Clear all counters and bresp_error.
- start while busy: ignored.
- start with FB=0 and PB=0: no bus activity; idle stays high from the next cycle.
- AW FSM, states IDLE, FULL, PARTIAL, DONE:
  - IDLE->FULL if FB!=0: AWADDR=0, AWLEN=BLOCK_CYCLES-1.
  - IDLE->PARTIAL if FB==0 and PB!=0: AWADDR=0, AWLEN=PB-1.
  - In FULL, on AWVALID&AWREADY: AWADDR += BURST_BYTES.
    - If more full bursts remain, stay in FULL.
    - Else if PB!=0, go to PARTIAL with AWLEN=PB-1.
    - Else go to DONE.
  - PARTIAL -> DONE on handshake.
  - DONE -> IDLE when W is complete and b_count==total_bursts.
  - AWVALID = (state==FULL or PARTIAL); AWADDR/AWLEN stay stable while AWVALID is high.
- W path runs independently of AW; W beats may precede their AW.
  - w_active is high from start until beat_total == FB*BLOCK_CYCLES+PB.
  - WDATA=AXIS_IN_TDATA.
  - WVALID = AXIS_IN_TVALID & w_active.
  - AXIS_IN_TREADY = M_AXI_WREADY & w_active.
  - No stream beat is accepted outside w_active.
  - beat_in_burst counts handshakes and resets to 0 after the last beat of each burst.
  - WLAST=1 on beat BLOCK_CYCLES-1 of full bursts, and on beat PB-1 of the partial burst (the final burst when PB!=0).
- B path: b_count increments on each BVALID.
  - If BRESP!=0, bresp_error<=1.
  - B responses beyond total_bursts are ignored for counting.
- idle = (AW state==IDLE) & !start.
- Simultaneous events: AW, W and B handshakes in the same cycle are all counted.
- Reset mid-operation: FSM returns to IDLE; AWVALID, WVALID, TREADY and bresp_error go 0 on the next edge. Outstanding bus transactions are abandoned and are the system's responsibility.
- Reset values: AWVALID=0, WVALID=0, WLAST=0, AXIS_IN_TREADY=0, bresp_error=0, idle=1 (when start=0).

Test Plan:
- BLOCK_CYCLES=4, FB=3, PB=0, AWREADY/WREADY/TVALID always 1:
  - AW addresses 0, 256, 512 (DW=512), all AWLEN=3.
  - 12 W beats with WLAST on beats 3, 7, 11.
  - idle rises one cycle after the 3rd BVALID.
- FB=2, PB=3:
  - Third AW at address 2*BURST_BYTES with AWLEN=2.
  - WLAST on beat 10.
  - Exactly 11 stream beats accepted; TREADY=0 thereafter even with TVALID=1.
- FB=0, PB=1:
  - Single AW with AWLEN=0.
  - One beat, WLAST=1.
  - Completes after 1 B response.
- FB=0, PB=0: idle low only during the start cycle; no AWVALID or WVALID ever asserted.
- Random AWREADY/WREADY/TVALID/BVALID stalls, FB=5, PB=7:
  - Data order is preserved and AW signals are stable while stalled.
  - BRESP=2 on the 2nd response sets bresp_error; it is cleared by the next start.
- Assert resetn=0 mid-burst (beat 2 of 4): next cycle AWVALID=WVALID=TREADY=0 and idle=1; a new start runs cleanly from address 0.

Source files
------------

// File: rtl/ram_writer.sv
// ram_writer: writes an AXI-Stream sequentially into RAM from address 0 using AXI4 bursts.
// N full bursts of BLOCK_CYCLES beats, then an optional partial burst; done once every B arrives.
module ram_writer #(
  parameter int DW           = 512,
  parameter int IW           = 5,
  parameter int BLOCK_CYCLES = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       full_blocks,
  input  logic [7:0]        partial_block_cycles,
  input  logic              start,
  output logic              idle,
  output logic              bresp_error,
  input  logic [DW-1:0]     AXIS_IN_TDATA,
  input  logic              AXIS_IN_TVALID,
  output logic              AXIS_IN_TREADY,
  output logic [63:0]       M_AXI_AWADDR,
  output logic [7:0]        M_AXI_AWLEN,
  output logic [2:0]        M_AXI_AWSIZE,
  output logic [IW-1:0]     M_AXI_AWID,
  output logic [1:0]        M_AXI_AWBURST,
  output logic              M_AXI_AWLOCK,
  output logic [3:0]        M_AXI_AWCACHE,
  output logic [3:0]        M_AXI_AWQOS,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [DW-1:0]     M_AXI_WDATA,
  output logic [DW/8-1:0]   M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  output logic              M_AXI_WLAST,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [63:0]       M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [IW-1:0]     M_AXI_ARID,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARLOCK,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [3:0]        M_AXI_ARQOS,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DW-1:0]     M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  input  logic [IW-1:0]     M_AXI_RID,
  output logic              M_AXI_RREADY
);
  localparam int BURST_BYTES = BLOCK_CYCLES * DW / 8;
  typedef enum logic [1:0] {IDLE, FULL, PARTIAL, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_fb, r_aw_cnt;
  logic [7:0]  r_pb, r_beat, r_awlen;
  logic [32:0] r_total, r_w_bursts, r_b_count;
  logic [63:0] r_awaddr;
  logic        r_w_active, r_bresp_error;
  logic        w_start, w_aw_hs, w_w_hs, w_last_full, w_partial, w_wlast, w_unused;
  assign w_start     = start & (r_state == IDLE);
  assign w_aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_w_hs      = M_AXI_WVALID & M_AXI_WREADY;
  assign w_last_full = (r_aw_cnt + 32'd1 == r_fb);
  // the W side tracks its own burst count since W beats may run ahead of AW
  assign w_partial   = (r_w_bursts == {1'b0, r_fb});
  assign w_wlast     = r_w_active & (w_partial ? r_beat == r_pb - 8'd1 : r_beat == 8'(BLOCK_CYCLES - 1));
  always_ff @(posedge clk) r_state <= !resetn ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = full_blocks != 0 ? FULL : partial_block_cycles != 0 ? PARTIAL : IDLE;
      FULL:    if (w_aw_hs) w_next = !w_last_full ? FULL : r_pb != 0 ? PARTIAL : DONE;
      PARTIAL: if (w_aw_hs) w_next = DONE;
      DONE:    if (!r_w_active && r_b_count == r_total) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    M_AXI_AWVALID = (r_state == FULL) || (r_state == PARTIAL);
    idle          = (r_state == IDLE) && !start;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fb          <= '0;
      r_pb          <= '0;
      r_total       <= '0;
      r_aw_cnt      <= '0;
      r_w_bursts    <= '0;
      r_b_count     <= '0;
      r_beat        <= '0;
      r_awaddr      <= '0;
      r_awlen       <= '0;
      r_w_active    <= 1'b0;
      r_bresp_error <= 1'b0;
    end else if (w_start) begin
      r_fb          <= full_blocks;
      r_pb          <= partial_block_cycles;
      r_total       <= {1'b0, full_blocks} + 33'(partial_block_cycles != 8'd0);
      r_aw_cnt      <= '0;
      r_w_bursts    <= '0;
      r_b_count     <= '0;
      r_beat        <= '0;
      r_awaddr      <= '0;
      r_awlen       <= full_blocks != 0 ? 8'(BLOCK_CYCLES - 1) : partial_block_cycles - 8'd1;
      r_w_active    <= (full_blocks != 0) || (partial_block_cycles != 0);
      r_bresp_error <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awaddr <= r_awaddr + 64'(BURST_BYTES);
        r_aw_cnt <= r_aw_cnt + 32'd1;
        r_awlen  <= (r_state == FULL && w_last_full) ? r_pb - 8'd1 : r_awlen;
      end
      if (w_w_hs) begin
        r_beat <= w_wlast ? 8'd0 : r_beat + 8'd1;
        if (w_wlast) r_w_bursts <= r_w_bursts + 33'd1;
        if (w_wlast && r_w_bursts + 33'd1 == r_total) r_w_active <= 1'b0;
      end
      if (M_AXI_BVALID && r_b_count != r_total) r_b_count <= r_b_count + 33'd1;
      if (M_AXI_BVALID && M_AXI_BRESP != 2'd0) r_bresp_error <= 1'b1;
    end
  end
  assign bresp_error    = r_bresp_error;
  assign AXIS_IN_TREADY = M_AXI_WREADY & r_w_active;
  assign M_AXI_AWADDR   = r_awaddr;
  assign M_AXI_AWLEN    = r_awlen;
  assign M_AXI_AWSIZE   = 3'($clog2(DW / 8));
  assign M_AXI_AWID     = '0;
  assign M_AXI_AWBURST  = 2'b01;
  assign M_AXI_AWLOCK   = 1'b0;
  assign M_AXI_AWCACHE  = '0;
  assign M_AXI_AWQOS    = '0;
  assign M_AXI_AWPROT   = '0;
  assign M_AXI_WDATA    = AXIS_IN_TDATA;
  assign M_AXI_WSTRB    = '1;
  assign M_AXI_WVALID   = AXIS_IN_TVALID & r_w_active;
  assign M_AXI_WLAST    = w_wlast;
  assign M_AXI_BREADY   = 1'b1;
  assign M_AXI_ARADDR   = '0;
  assign M_AXI_ARLEN    = '0;
  assign M_AXI_ARSIZE   = '0;
  assign M_AXI_ARID     = '0;
  assign M_AXI_ARBURST  = '0;
  assign M_AXI_ARLOCK   = 1'b0;
  assign M_AXI_ARCACHE  = '0;
  assign M_AXI_ARQOS    = '0;
  assign M_AXI_ARPROT   = '0;
  assign M_AXI_ARVALID  = 1'b0;
  assign M_AXI_RREADY   = 1'b0;
  assign w_unused = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RID};
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: table-driven transfers against a queue scoreboard with a random AXI slave.
module tb_ram_writer;
  localparam int DW = 512, IW = 5, BC = 4, BB = BC * DW / 8;
  logic clk = 0;
  always #5 clk = ~clk;
  logic resetn, start, idle, bresp_error;
  logic [31:0] full_blocks;
  logic [7:0] partial_block_cycles;
  logic [DW-1:0] AXIS_IN_TDATA, M_AXI_WDATA, M_AXI_RDATA;
  logic AXIS_IN_TVALID, AXIS_IN_TREADY;
  logic [63:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [7:0] M_AXI_AWLEN, M_AXI_ARLEN;
  logic [2:0] M_AXI_AWSIZE, M_AXI_AWPROT, M_AXI_ARSIZE, M_AXI_ARPROT;
  logic [IW-1:0] M_AXI_AWID, M_AXI_ARID, M_AXI_RID;
  logic [1:0] M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
  logic M_AXI_AWLOCK, M_AXI_ARLOCK, M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic [3:0] M_AXI_AWCACHE, M_AXI_AWQOS, M_AXI_ARCACHE, M_AXI_ARQOS;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  ram_writer #(.DW(DW), .IW(IW), .BLOCK_CYCLES(BC)) dut (
    .clk(clk), .resetn(resetn), .full_blocks(full_blocks), .partial_block_cycles(partial_block_cycles),
    .start(start), .idle(idle), .bresp_error(bresp_error),
    .AXIS_IN_TDATA(AXIS_IN_TDATA), .AXIS_IN_TVALID(AXIS_IN_TVALID), .AXIS_IN_TREADY(AXIS_IN_TREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWQOS(M_AXI_AWQOS), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARQOS(M_AXI_ARQOS), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RID(M_AXI_RID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  typedef struct {
    int fb; int pb; int aw_p; int w_p; int tv_p; int b_p; int err_idx;
    bit exp_err; int exp_beats; int exp_bursts;
  } vec_t;
  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_t;
  aw_t aw_q[$];
  w_t w_q[$];
  int total = 0, bad = 0, cyc = 0;
  int aw_p = 100, w_p = 100, tv_p = 100, b_p = 100, err_idx = -1;
  int cur_fb = 0, cur_pb = 0, beats_total = 0, beats_pushed = 0, beats_acc = 0;
  int aw_done = 0, wl_done = 0, b_sent = 0, last_b_cyc = 0;
  bit need_new = 0, prev_stall = 0, rst_n = 0, start_r = 0;
  logic [63:0] prev_addr;
  logic [7:0] prev_len;
  logic [DW-1:0] cur_data = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic exp_last(input int k);
    if (k < cur_fb * BC) return (k % BC) == BC - 1;
    return (k - cur_fb * BC) == cur_pb - 1;
  endfunction

  task automatic drive();
    int owed;
    resetn = rst_n;
    start = start_r;
    full_blocks = 32'(cur_fb);
    partial_block_cycles = 8'(cur_pb);
    M_AXI_AWREADY = roll(aw_p);
    M_AXI_WREADY = roll(w_p);
    AXIS_IN_TVALID = roll(tv_p);
    if (need_new && beats_pushed < beats_total) begin
      for (int j = 0; j < DW / 32; j++) cur_data[j*32 +: 32] = $urandom;
      w_q.push_back('{cur_data, exp_last(beats_pushed)});
      beats_pushed++;
      need_new = 0;
    end
    AXIS_IN_TDATA = cur_data;
    owed = (aw_done < wl_done ? aw_done : wl_done) - b_sent;
    M_AXI_BVALID = rst_n && owed > 0 && roll(b_p);
    M_AXI_BRESP = (b_sent == err_idx) ? 2'd2 : 2'd0;
  endtask

  // handshakes seen here complete on the following rising edge
  task automatic mon();
    aw_t a;
    w_t w;
    if (!rst_n) return;
    if (prev_stall) begin
      chk("aw_hold_valid", DW'(M_AXI_AWVALID), DW'(1));
      chk("aw_hold_addr", DW'(M_AXI_AWADDR), DW'(prev_addr));
      chk("aw_hold_len", DW'(M_AXI_AWLEN), DW'(prev_len));
    end
    if (M_AXI_AWVALID && aw_q.size() == 0) chk("aw_unexpected", DW'(M_AXI_AWVALID), DW'(0));
    else if (M_AXI_AWVALID && M_AXI_AWREADY) begin
      a = aw_q.pop_front();
      chk("awaddr", DW'(M_AXI_AWADDR), DW'(a.addr));
      chk("awlen", DW'(M_AXI_AWLEN), DW'(a.len));
      chk("awsize", DW'(M_AXI_AWSIZE), DW'(6));
      chk("awburst", DW'(M_AXI_AWBURST), DW'(1));
      aw_done++;
    end
    prev_stall = M_AXI_AWVALID && !M_AXI_AWREADY;
    prev_addr = M_AXI_AWADDR;
    prev_len = M_AXI_AWLEN;
    if (w_q.size() == 0) begin
      chk("w_off_valid", DW'(M_AXI_WVALID), DW'(0));
      chk("w_off_tready", DW'(AXIS_IN_TREADY), DW'(0));
    end else if (M_AXI_WVALID && M_AXI_WREADY) begin
      w = w_q.pop_front();
      chk("tready", DW'(AXIS_IN_TREADY), DW'(1));
      chk("wdata", M_AXI_WDATA, w.data);
      chk("wlast", DW'(M_AXI_WLAST), DW'(w.last));
      chk("wstrb", DW'(M_AXI_WSTRB), DW'({(DW/8){1'b1}}));
      beats_acc++;
      if (w.last) wl_done++;
      need_new = 1;
    end
    if (M_AXI_BVALID) begin
      chk("bready", DW'(M_AXI_BREADY), DW'(1));
      b_sent++;
      last_b_cyc = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    mon();
  endtask

  task automatic setup(input vec_t v);
    cur_fb = v.fb; cur_pb = v.pb;
    aw_p = v.aw_p; w_p = v.w_p; tv_p = v.tv_p; b_p = v.b_p; err_idx = v.err_idx;
    beats_total = v.fb * BC + v.pb;
    beats_pushed = 0; beats_acc = 0; aw_done = 0; wl_done = 0; b_sent = 0;
    need_new = 1;
    aw_q.delete();
    w_q.delete();
    for (int i = 0; i < v.fb; i++) aw_q.push_back('{64'(i * BB), 8'(BC - 1)});
    if (v.pb != 0) aw_q.push_back('{64'(v.fb * BB), 8'(v.pb - 1)});
  endtask

  task automatic run(input vec_t v, input bit lat);
    int n;
    setup(v);
    start_r = 1;
    step();
    chk("idle_on_start", DW'(idle), DW'(0));
    start_r = 0;
    step();
    chk("err_cleared", DW'(bresp_error), DW'(0));
    n = 0;
    while (!idle && n < 3000) begin
      step();
      n++;
    end
    chk("finish_timeout", DW'(n >= 3000), DW'(0));
    if (lat) chk("idle_latency", DW'(cyc - last_b_cyc), DW'(2));
    repeat (6) step();
    chk("beats_accepted", DW'(beats_acc), DW'(v.exp_beats));
    chk("b_responses", DW'(b_sent), DW'(v.exp_bursts));
    chk("aw_missing", DW'(aw_q.size()), DW'(0));
    chk("bresp_error", DW'(bresp_error), DW'(v.exp_err));
  endtask

  initial begin
    vec_t vt[6];
    int n;
    resetn = 0; start = 0; full_blocks = 0; partial_block_cycles = 0;
    AXIS_IN_TDATA = '0; AXIS_IN_TVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_ARREADY = 0; M_AXI_RDATA = '0;
    M_AXI_RRESP = 0; M_AXI_RLAST = 0; M_AXI_RVALID = 0; M_AXI_RID = '0;
    vt[0] = '{3, 0, 100, 100, 100, 100, -1, 0, 12, 3};
    vt[1] = '{2, 3, 100, 100, 100, 100, -1, 0, 11, 3};
    vt[2] = '{0, 1, 100, 100, 100, 100, -1, 0, 1, 1};
    vt[3] = '{5, 7, 60, 70, 60, 50, 1, 1, 27, 6};
    vt[4] = '{0, 0, 100, 100, 100, 100, -1, 0, 0, 0};
    vt[5] = '{1, 2, 50, 50, 50, 50, 0, 1, 6, 2};
    rst_n = 0;
    repeat (3) step();
    chk("rst_awvalid", DW'(M_AXI_AWVALID), DW'(0));
    chk("rst_wvalid", DW'(M_AXI_WVALID), DW'(0));
    chk("rst_wlast", DW'(M_AXI_WLAST), DW'(0));
    chk("rst_tready", DW'(AXIS_IN_TREADY), DW'(0));
    chk("rst_bresp_error", DW'(bresp_error), DW'(0));
    chk("rst_idle", DW'(idle), DW'(1));
    rst_n = 1;
    step();
    for (int i = 0; i < 6; i++) run(vt[i], i == 0);
    setup('{2, 0, 100, 100, 100, 100, -1, 0, 8, 2});
    start_r = 1;
    step();
    start_r = 0;
    n = 0;
    while (beats_acc < 2 && n < 100) begin
      step();
      n++;
    end
    chk("midburst_timeout", DW'(n >= 100), DW'(0));
    rst_n = 0;
    step();
    step();
    chk("mid_rst_awvalid", DW'(M_AXI_AWVALID), DW'(0));
    chk("mid_rst_wvalid", DW'(M_AXI_WVALID), DW'(0));
    chk("mid_rst_tready", DW'(AXIS_IN_TREADY), DW'(0));
    chk("mid_rst_idle", DW'(idle), DW'(1));
    rst_n = 1;
    aw_q.delete();
    w_q.delete();
    prev_stall = 0; beats_total = 0; beats_pushed = 0; need_new = 0;
    aw_done = 0; wl_done = 0; b_sent = 0;
    step();
    run('{1, 0, 100, 100, 100, 100, -1, 0, 4, 1}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
